// File: rtl/transfer_order_sequencer.sv
// -----------------------------------------------------------------------------
// transfer_order_sequencer
//
// Runs the store-transfer orders T (store and clear Accumulator), U (store and
// retain) and H (memory to Multiplier) through the tank-clear/end-pulse
// control unit. An accepted order drives its order lines for the whole order.
// The unit fires s2 once, on the first even-minor-cycle d0 pulse after the
// order is accepted. It then waits for the matching end pulse. For H there is
// no end pulse: the order ends at the odd_d0 / next ev_d0 window that clears
// the Multiplier. Each order ends in exactly one of a done pulse, a timeout
// pulse, or an illegal-order pulse.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   start, order  one-cycle request and the 5-bit function code it carries
//   ev_d0, odd_d0 d0 pulses of the even / odd minor cycle
//   ep6, ep7      end pulses: store-and-clear / store-and-retain
//   c18,c19,c20   order lines (H; T or U; T)
//   op_u          U order line
//   s2            stimulating pulse, one cycle
//   busy          an order is in progress
//   done          one-cycle completion pulse
//   err_timeout   one-cycle pulse: MAX_MINOR even minor cycles without an end
//   err_illegal   one-cycle pulse: start carried a code outside {T, U, H}
// -----------------------------------------------------------------------------
module transfer_order_sequencer #(
  parameter logic [4:0]  ORD_T     = 5'd5,
  parameter logic [4:0]  ORD_U     = 5'd7,
  parameter logic [4:0]  ORD_H     = 5'd21,
  parameter int unsigned MAX_MINOR = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] order,
  input  logic       ev_d0,
  input  logic       odd_d0,
  input  logic       ep6,
  input  logic       ep7,
  output logic       c18,
  output logic       c19,
  output logic       c20,
  output logic       op_u,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_illegal
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARM      = 3'd1;
  localparam logic [2:0] ST_WAIT_END = 3'd2;
  localparam logic [2:0] ST_H_ODD    = 3'd3;
  localparam logic [2:0] ST_H_EV     = 3'd4;

  localparam logic [7:0] MAX_CNT = 8'(MAX_MINOR);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       c18_q, c18_d;
  logic       c19_q, c19_d;
  logic       c20_q, c20_d;
  logic       op_u_q, op_u_d;
  logic       s2_q, s2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_illegal_q, err_illegal_d;

  logic [7:0] cnt_inc;
  logic       complete;
  logic       finish;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    c18_d         = c18_q;
    c19_d         = c19_q;
    c20_d         = c20_q;
    op_u_d        = op_u_q;
    busy_d        = busy_q;
    s2_d          = 1'b0;
    done_d        = 1'b0;
    err_timeout_d = 1'b0;
    err_illegal_d = 1'b0;
    complete      = 1'b0;
    finish        = 1'b0;
    cnt_inc       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        // The done / timeout cycle already shows IDLE, but it still belongs to
        // the order that just ended. A start that arrives then is dropped.
        if (start && !done_q && !err_timeout_q) begin
          busy_d  = 1'b1;
          state_d = ST_ARM;
          if (order == ORD_T) begin
            c19_d = 1'b1;
            c20_d = 1'b1;
          end else if (order == ORD_U) begin
            c19_d  = 1'b1;
            op_u_d = 1'b1;
          end else if (order == ORD_H) begin
            c18_d = 1'b1;
          end else begin
            busy_d        = 1'b0;
            state_d       = ST_IDLE;
            err_illegal_d = 1'b1;
          end
        end
      end

      // ARM is entered one cycle after start. An ev_d0 that arrives together
      // with start is therefore never seen here.
      ST_ARM: begin
        if (ev_d0) begin
          s2_d    = 1'b1;
          cnt_d   = 8'd0;
          state_d = c18_q ? ST_H_ODD : ST_WAIT_END;
        end
      end

      ST_WAIT_END, ST_H_ODD, ST_H_EV: begin
        if (ev_d0) cnt_d = cnt_inc;
        // c20 marks T (ends on ep6); op_u marks U (ends on ep7). The other
        // end pulse falls through and is ignored.
        complete = ((state_q == ST_WAIT_END) && ((c20_q && ep6) || (op_u_q && ep7)))
                 || ((state_q == ST_H_EV) && ev_d0);
        if (complete) begin
          done_d = 1'b1;
          finish = 1'b1;
        end else if (ev_d0 && (cnt_inc == MAX_CNT)) begin
          err_timeout_d = 1'b1;
          finish        = 1'b1;
        end else if ((state_q == ST_H_ODD) && odd_d0 && !ev_d0) begin
          // When ev_d0 and odd_d0 are both high, ev_d0 wins. That cycle only
          // counts; it does not open the Multiplier-clear window.
          state_d = ST_H_EV;
        end
      end

      default: finish = 1'b1;
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      busy_d  = 1'b0;
      c18_d   = 1'b0;
      c19_d   = 1'b0;
      c20_d   = 1'b0;
      op_u_d  = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      c18_q         <= 1'b0;
      c19_q         <= 1'b0;
      c20_q         <= 1'b0;
      op_u_q        <= 1'b0;
      s2_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      c18_q         <= c18_d;
      c19_q         <= c19_d;
      c20_q         <= c20_d;
      op_u_q        <= op_u_d;
      s2_q          <= s2_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign c18         = c18_q;
  assign c19         = c19_q;
  assign c20         = c20_q;
  assign op_u        = op_u_q;
  assign s2          = s2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_transfer_order_sequencer.sv
// -----------------------------------------------------------------------------
// tb_transfer_order_sequencer
//
// Builds a per-cycle input schedule in advance: directed scenarios first, then
// random traffic. A transaction-level model turns that schedule into expected
// output vectors. For each accepted order the model finds these cycles:
//   - the arming ev_d0,
//   - the ending pulse or window,
//   - the MAX_MINOR-th counted ev_d0,
//   - any reset.
// It then fills in the cycles where each output must be high. The bench
// compares every cycle with the model, plus fixed cycles of the directed
// scenarios.
// -----------------------------------------------------------------------------
module tb_transfer_order_sequencer;

  localparam int N    = 3000;
  localparam int MAXM = 4;
  localparam int INF  = N + 1000;

  // Bit positions in the observed / expected output vector.
  localparam int B_C18  = 8;
  localparam int B_C19  = 7;
  localparam int B_C20  = 6;
  localparam int B_OPU  = 5;
  localparam int B_S2   = 4;
  localparam int B_BUSY = 3;
  localparam int B_DONE = 2;
  localparam int B_TO   = 1;
  localparam int B_ILL  = 0;

  logic       clk = 1'b0;
  logic       rst, start, ev_d0, odd_d0, ep6, ep7;
  logic [4:0] order;
  logic       c18, c19, c20, op_u, s2, busy, done, err_timeout, err_illegal;
  logic [8:0] obs_v;

  bit       rst_a [N];
  bit       st_a  [N];
  bit       ev_a  [N];
  bit       odd_a [N];
  bit       e6_a  [N];
  bit       e7_a  [N];
  bit [4:0] ord_a [N];
  bit [8:0] exp_a [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  transfer_order_sequencer #(
    .ORD_T(5'd5), .ORD_U(5'd7), .ORD_H(5'd21), .MAX_MINOR(MAXM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .order(order),
    .ev_d0(ev_d0), .odd_d0(odd_d0), .ep6(ep6), .ep7(ep7),
    .c18(c18), .c19(c19), .c20(c20), .op_u(op_u), .s2(s2), .busy(busy),
    .done(done), .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  assign obs_v = {c18, c19, c20, op_u, s2, busy, done, err_timeout, err_illegal};

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  // First cycle >= from where the chosen input event occurs.
  // kind: 0 ev_d0, 1 odd_d0 without ev_d0, 2 ep6, 3 ep7, 4 rst.
  function automatic int first_from(input int from, input int kind);
    for (int c = from; c < N; c++) begin
      case (kind)
        0: if (ev_a[c]) return c;
        1: if (odd_a[c] && !ev_a[c]) return c;
        2: if (e6_a[c]) return c;
        3: if (e7_a[c]) return c;
        default: if (rst_a[c]) return c;
      endcase
    end
    return INF;
  endfunction

  function automatic int nth_ev(input int from, input int n);
    int seen = 0;
    for (int c = from; c < N; c++) begin
      if (ev_a[c]) begin
        seen++;
        if (seen == n) return c;
      end
    end
    return INF;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic build_model();
    int free = 0;
    int r, t, c1, c_done, c_to, e, last;
    logic [8:0] lines;
    for (int k = 0; k < N; k++) begin
      if (rst_a[k] || !st_a[k] || k < free) continue;
      r = first_from(k + 1, 4);
      lines = '0;
      if (ord_a[k] == 5'd5) begin
        lines[B_C19] = 1'b1; lines[B_C20] = 1'b1;
      end else if (ord_a[k] == 5'd7) begin
        lines[B_C19] = 1'b1; lines[B_OPU] = 1'b1;
      end else if (ord_a[k] == 5'd21) begin
        lines[B_C18] = 1'b1;
      end else begin
        if (k + 1 < N) exp_a[k + 1][B_ILL] = 1'b1;
        free = k + 1;
        continue;
      end
      lines[B_BUSY] = 1'b1;
      t = first_from(k + 1, 0);
      if (t >= INF) begin
        c_done = INF;
        c_to   = INF;
      end else begin
        c_to = nth_ev(t + 1, MAXM);
        if (ord_a[k] == 5'd5)      c_done = first_from(t + 1, 2);
        else if (ord_a[k] == 5'd7) c_done = first_from(t + 1, 3);
        else begin
          c1     = first_from(t + 1, 1);
          c_done = (c1 >= INF) ? INF : first_from(c1 + 1, 0);
        end
      end
      e    = imin(c_done, c_to);
      last = imin(imin(e, r), N - 1);
      for (int c = k + 1; c <= last; c++) exp_a[c] = exp_a[c] | lines;
      if (t < INF && t + 1 <= r && t + 1 < N) exp_a[t + 1][B_S2] = 1'b1;
      if (e < INF && e + 1 <= r && e + 1 < N) begin
        if (c_done <= c_to) exp_a[e + 1][B_DONE] = 1'b1;
        else                exp_a[e + 1][B_TO]   = 1'b1;
      end
      free = imin(r, e + 1) + 1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; order = 5'd0;
    ev_d0 = 1'b0; odd_d0 = 1'b0; ep6 = 1'b0; ep7 = 1'b0;

    // Reset at power-up.
    rst_a[0] = 1'b1; rst_a[1] = 1'b1; rst_a[2] = 1'b1;
    // T order: arms on ev_d0 at 14, ends on ep6 at 20.
    st_a[10] = 1'b1; ord_a[10] = 5'd5;
    ev_a[14] = 1'b1; e6_a[20] = 1'b1; ev_a[22] = 1'b1;
    // U order: ep6 at 46 must be ignored; T start at 45 while busy.
    st_a[40] = 1'b1; ord_a[40] = 5'd7;
    ev_a[43] = 1'b1; e6_a[46] = 1'b1; e7_a[49] = 1'b1;
    st_a[45] = 1'b1; ord_a[45] = 5'd5;
    // H order: arms at 72, window opens on odd_d0 at 76, closes at 80.
    st_a[70] = 1'b1; ord_a[70] = 5'd21;
    ev_a[72] = 1'b1; odd_a[76] = 1'b1; ev_a[80] = 1'b1;
    // T order without ep6: times out after the 4th counted ev_d0.
    st_a[100] = 1'b1; ord_a[100] = 5'd5;
    for (int c = 104; c <= 140; c += 4) ev_a[c] = 1'b1;
    // Illegal code.
    st_a[150] = 1'b1; ord_a[150] = 5'd3;
    // Reset during WAIT_END of a T order, then a normal H order.
    st_a[170] = 1'b1; ord_a[170] = 5'd5; ev_a[172] = 1'b1;
    rst_a[178] = 1'b1;
    st_a[185] = 1'b1; ord_a[185] = 5'd21;
    ev_a[188] = 1'b1; odd_a[190] = 1'b1; ev_a[194] = 1'b1;
    // H order: ev_d0 and odd_d0 together in H_ODD must not advance.
    st_a[210] = 1'b1; ord_a[210] = 5'd21;
    ev_a[212] = 1'b1; ev_a[215] = 1'b1; odd_a[215] = 1'b1; ev_a[216] = 1'b1;
    odd_a[217] = 1'b1; ev_a[219] = 1'b1;
    // U order: ev_d0 in the start cycle is not used; start in the done cycle is dropped.
    st_a[240] = 1'b1; ord_a[240] = 5'd7; ev_a[240] = 1'b1;
    ev_a[243] = 1'b1; e7_a[246] = 1'b1;
    st_a[247] = 1'b1; ord_a[247] = 5'd7;

    // Random traffic.
    for (int c = 300; c < N; c++) begin
      ev_a[c]  = ($urandom_range(0, 3) == 0);
      odd_a[c] = ($urandom_range(0, 3) == 0);
      e6_a[c]  = ($urandom_range(0, 7) == 0);
      e7_a[c]  = ($urandom_range(0, 7) == 0);
      if (c < N - 200) begin
        st_a[c]  = ($urandom_range(0, 5) == 0);
        rst_a[c] = ($urandom_range(0, 299) == 0);
        case ($urandom_range(0, 3))
          0:       ord_a[c] = 5'd5;
          1:       ord_a[c] = 5'd7;
          2:       ord_a[c] = 5'd21;
          default: ord_a[c] = 5'($urandom_range(0, 31));
        endcase
      end
    end

    build_model();

    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      rst    = rst_a[c];
      start  = st_a[c];
      order  = ord_a[c];
      ev_d0  = ev_a[c];
      odd_d0 = odd_a[c];
      ep6    = e6_a[c];
      ep7    = e7_a[c];
      @(negedge clk);
      if (c >= 1) begin
        check($sformatf("cycle %0d outputs", c), obs_v, exp_a[c]);
        case (c)
          11:  check("T lines", {6'd0, c19, c20, op_u}, 9'b110);
          15:  check("T s2", {8'd0, s2}, 9'd1);
          16:  check("T s2 single", {8'd0, s2}, 9'd0);
          21:  check("T done lines", {6'd0, done, c19, c20}, 9'b100);
          47:  check("U ep6 ignored", {8'd0, done}, 9'd0);
          50:  check("U done c20", {7'd0, done, c20}, 9'b10);
          80:  check("H c18", {8'd0, c18}, 9'd1);
          81:  check("H done", {7'd0, done, c18}, 9'b10);
          121: check("timeout", {7'd0, err_timeout, done}, 9'b10);
          130: check("post-timeout idle", {8'd0, busy}, 9'd0);
          151: check("illegal", {7'd0, err_illegal, busy}, 9'b10);
          179: check("reset mid-order", obs_v, 9'd0);
          195: check("H after reset", {8'd0, done}, 9'd1);
          217: check("ev+odd no advance", {8'd0, done}, 9'd0);
          220: check("H done after ev+odd", {8'd0, done}, 9'd1);
          241: check("start-cycle ev unused", {8'd0, s2}, 9'd0);
          244: check("s2 on later ev", {8'd0, s2}, 9'd1);
          247: check("U done", {8'd0, done}, 9'd1);
          248: check("start at done dropped", {8'd0, busy}, 9'd0);
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
